// File: rtl/param_mux_stream_reg.sv
// param_mux_stream_reg: NUM_IN-way streaming mux into one registered output stage.
// Source is picked by an explicit select (mode 0) or by a round-robin arbiter
// (mode 1). The output stage is a single valid/ready register that can drain
// and reload in the same cycle, so a ready consumer sees one word per cycle.
// SEL_W must be wide enough to index every channel (2**SEL_W >= NUM_IN).

// Per-channel accept decode: a lane is ready only when it holds the grant and
// the output register can take a word this cycle.
module param_mux_stream_reg_lane #(
    parameter int SEL_W = 1,
    parameter int IDX   = 0
) (
    input  logic             en,
    input  logic             gnt_vld,
    input  logic [SEL_W-1:0] gnt_idx,
    output logic             ready
);
    assign ready = en && gnt_vld && (gnt_idx == SEL_W'(IDX));
endmodule

module param_mux_stream_reg #(
    parameter int WIDTH  = 6,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    int               j;

    // The register may take a new word when empty or when it drains this cycle.
    assign load_en = !out_valid || out_ready;

    // Grant selection. Mode 0 only grants an in-range sel; out-of-range sel never
    // matches a lane so nothing is granted. Mode 1 scans cyclically from rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_IN) j = j - NUM_IN;
                if (!gnt_vld && in_valid[j]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(j);
                end
            end
        end
    end

    // Data steering for the granted channel (constant slices only).
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // One accept decoder per channel; reset gates every ready low.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
            param_mux_stream_reg_lane #(.SEL_W(SEL_W), .IDX(gi)) u_lane (
                .en      (reset_n && load_en),
                .gnt_vld (gnt_vld),
                .gnt_idx (gnt_idx),
                .ready   (in_ready[gi])
            );
        end
    endgenerate

    // Output register and round-robin pointer. The pointer only advances on a
    // round-robin transfer, so switching back from mode 0 resumes where it left.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= gnt_data;
                out_src  <= gnt_idx;
                if (mode) begin
                    rr_ptr <= (gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end
endmodule
